test_result_writer: RTL

Bus-initiator counterpart of the simulation test-result sink. On a `start` pulse it latches an 8-bit status code. It then drives a byte-serial ASCII verdict onto the dmem write port at the test address, one byte per write with a valid/ready handshake. The verdict is "OK\n" for status 0, otherwise "ER" plus two uppercase hex digits plus "\n". It sits beside the core in unittest benches and in SoC self-test firmware replacements, sharing the dmem write path to the result device.

---
 rtl/test_result_writer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/test_result_writer.sv
// Byte-serial ASCII verdict writer: on start, latches a status code and writes "OK\n" or
// "ERxx\n" one byte per handshake to a fixed dmem address, with a one-cycle gap between bytes.
module test_result_writer #(
    parameter logic [31:0] TEST_ADDR = 32'h2000_0000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [7:0]  status,
    input  logic        dmem_ready,
    output logic        dmem_valid,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        busy,
    output logic        done,
    output logic        timeout_err
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WCNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap
    } state_e;

    state_e        r_state;
    state_e        w_state_d;
    logic [7:0]    r_code;
    logic [7:0]    w_code_d;
    logic [2:0]    r_len;
    logic [2:0]    w_len_d;
    logic [2:0]    r_idx;
    logic [2:0]    w_idx_d;
    logic [CW-1:0] r_wcnt;
    logic [CW-1:0] w_wcnt_d;
    logic          r_terr;
    logic          w_terr_d;
    logic          r_done;
    logic          w_done_d;
    logic [7:0]    w_byte;
    logic [7:0]    w_hex_hi;
    logic [7:0]    w_hex_lo;

    function automatic logic [7:0] hex_digit(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
            r_code  <= 8'h00;
            r_len   <= 3'd0;
            r_idx   <= 3'd0;
            r_wcnt  <= '0;
            r_terr  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_code  <= w_code_d;
            r_len   <= w_len_d;
            r_idx   <= w_idx_d;
            r_wcnt  <= w_wcnt_d;
            r_terr  <= w_terr_d;
            r_done  <= w_done_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_code_d  = r_code;
        w_len_d   = r_len;
        w_idx_d   = r_idx;
        w_wcnt_d  = r_wcnt;
        w_terr_d  = r_terr;
        w_done_d  = 1'b0;
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_code_d  = status;
                    w_len_d   = (status == 8'h00) ? 3'd3 : 3'd5;
                    w_idx_d   = 3'd0;
                    w_wcnt_d  = '0;
                    w_terr_d  = 1'b0;
                    w_state_d = StSend;
                end
            end
            StSend: begin
                // Acceptance wins over a timeout landing in the same cycle.
                if (dmem_ready) begin
                    w_wcnt_d = '0;
                    if (r_idx == r_len - 3'd1) begin
                        w_done_d  = 1'b1;
                        w_state_d = StIdle;
                    end else begin
                        w_idx_d   = r_idx + 3'd1;
                        w_state_d = StGap;
                    end
                end else if (r_wcnt == WCNT_LAST) begin
                    w_wcnt_d  = '0;
                    w_terr_d  = 1'b1;
                    w_state_d = StIdle;
                end else begin
                    w_wcnt_d = r_wcnt + 1'b1;
                end
            end
            StGap: begin
                w_wcnt_d  = '0;
                w_state_d = StSend;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign w_hex_hi = hex_digit(r_code[7:4]);
    assign w_hex_lo = hex_digit(r_code[3:0]);

    always_comb begin
        w_byte = 8'h0A;
        if (r_code == 8'h00) begin
            case (r_idx)
                3'd0:    w_byte = 8'h4F;
                3'd1:    w_byte = 8'h4B;
                default: w_byte = 8'h0A;
            endcase
        end else begin
            case (r_idx)
                3'd0:    w_byte = 8'h45;
                3'd1:    w_byte = 8'h52;
                3'd2:    w_byte = w_hex_hi;
                3'd3:    w_byte = w_hex_lo;
                default: w_byte = 8'h0A;
            endcase
        end
    end

    // Bus outputs decode from state only, so nothing combinational reaches them from inputs.
    assign dmem_valid  = (r_state == StSend);
    assign dmem_wmask  = dmem_valid ? 4'b0001 : 4'b0000;
    assign dmem_addr   = dmem_valid ? TEST_ADDR : 32'h0000_0000;
    assign dmem_wdata  = dmem_valid ? {24'h00_0000, w_byte} : 32'h0000_0000;
    assign busy        = (r_state != StIdle);
    assign done        = r_done;
    assign timeout_err = r_terr;

endmodule
